alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 8-bit ALU datapath. Loads a program into the 64x11 instruction
//  memory through a valid/ready port, then steps it: FETCH -> DECODE -> EXEC for each instruction.
//  Holds the accumulator (ALU operand 1) and registered Z/C/N flags. Replaces free-running PC and tie-offs.
// PARAMETERS
//  ADDR_W    6      instruction memory address width (64 words)
//  INSTR_W   11     instruction width: [10:8] opcode, [7:0] immediate operand
//  DATA_W    8      accumulator / ALU data width
//  ACC_INIT  8'h00  accumulator value loaded on start
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        run program at addr 0..prog_last; sampled in IDLE only
//  prog_last    in   ADDR_W   address of last instruction; sampled on start
//  halt_req     in   1        stop after the current instruction completes
//  load_valid   in   1        program word offered
//  load_data    in   INSTR_W  program word
//  load_ready   out  1        sequencer accepts load_data this cycle
//  mem_addr     out  ADDR_W   instruction memory address
//  mem_rw       out  1        1 = read, 0 = write (write on this clk edge)
//  mem_wdata    out  INSTR_W  instruction memory write data (= load_data)
//  mem_rdata    in   INSTR_W  registered memory read data, valid 1 cycle after address
//  alu_opcode   out  3        IR[10:8]
//  alu_operand  out  DATA_W   IR[7:0]
//  alu_in1      out  DATA_W   accumulator
//  alu_result   in   DATA_W   combinational ALU result
//  alu_zero/alu_carry/alu_negative  in  1 each  combinational ALU flags
//  flags        out  3        {N,C,Z} registered
//  busy         out  1        high in LOAD, FETCH, DECODE, EXEC
//  done         out  1        1-cycle pulse: program completed normally
//  halted       out  1        1-cycle pulse: run stopped by halt_req
// BEHAVIOUR
//  Reset values: state=IDLE, pc=0, load_ptr=0, IR=0, acc=ACC_INIT, flags=0, mem_rw=1, load_ready=0,
//   busy=0, done=0, halted=0. Reset mid-run or mid-load aborts immediately. Memory contents are untouched.
//  mem_rw=0 only in LOAD on a cycle with load_valid&&load_ready. Otherwise mem_rw=1.
//  IDLE: start=1 -> FETCH. Set pc=0, acc=ACC_INIT, flags=0, latch prog_last.
//   Else load_valid=1 -> LOAD with load_ptr=0. This transition does not write.
//   start has priority over load_valid.
//  LOAD: load_ready=1. mem_addr=load_ptr. Each load_valid cycle writes load_data and increments load_ptr.
//   load_ptr wraps 63->0 and overwrites address 0. load_valid=0 -> IDLE the next cycle.
//  FETCH: mem_addr=pc, mem_rw=1 -> DECODE.
//  DECODE: IR <= mem_rdata -> EXEC.
//  EXEC: ALU ports driven from IR/acc. At the clock edge, flags <= {alu_negative,alu_carry,alu_zero}.
//   acc <= alu_result unless opcode==3'b100 (compare), which leaves acc unchanged.
//   Next state: halt_req=1 -> HALTED; else pc==prog_last -> DONE; else pc<=pc+1 -> FETCH.
//   halt_req has priority over completion.
//  DONE: done=1 for one cycle -> IDLE. HALTED: halted=1 for one cycle -> IDLE. acc and flags are held.
//  Cost is 3 cycles per instruction. With N=prog_last+1 and the first FETCH cycle counted as cycle 1,
//   done is high in cycle 3N+1. pc never wraps: prog_last=63 runs 64 instructions.
//  start, load_valid and halt_req are ignored outside the states listed. No arithmetic is done here.
// TESTING
//  Load 3 words 0x205,0x2FF,0x404, prog_last=2, start -> acc 05 then 04 with C=1.
//   CMP leaves acc=04 with Z=1,C=1. done is high in cycle 10.
//  Load is paced by load_valid gaps. Check mem_rw=0 only on accepted beats and that load_ptr does not advance in gaps.
//   65 beats: word 65 overwrites address 0.
//  halt_req pulsed during the DECODE of instruction 2 of 4. Instruction 2 still updates acc.
//   halted pulses and done stays 0.
//  start and load_valid asserted together in IDLE -> FETCH is entered and no memory write occurs.
//  rst asserted in EXEC. All outputs take their reset values asynchronously.
//   A new start afterwards runs from pc=0 with acc=ACC_INIT.
//  SUB 0x003 from acc 0x01 (word 0x303) -> acc=02 magnitude with N=1.
//   A following OR 0x000 gives Z=0,N=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the 8-bit ALU datapath: loads a program into instruction memory
// through a valid/ready port, then runs it as FETCH -> DECODE -> EXEC per instruction.
module alu_seq_ctrl #(
  parameter int                ADDR_W   = 6,
  parameter int                INSTR_W  = 11,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] ACC_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  prog_last,
  input  logic               halt_req,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rw,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [2:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_operand,
  output logic [DATA_W-1:0]  alu_in1,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_negative,
  output logic [2:0]         flags,
  output logic               busy,
  output logic               done,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_DONE, S_HALTED
  } state_t;

  localparam logic [2:0] OP_CMP = 3'b100;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W-1:0]   load_ptr_reg, load_ptr_next;
  logic [ADDR_W-1:0]   last_reg, last_next;
  logic [INSTR_W-1:0]  ir_reg, ir_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic [2:0]          flags_reg, flags_next;
  logic                halt_pend_reg, halt_pend_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      load_ptr_reg  <= '0;
      last_reg      <= '0;
      ir_reg        <= '0;
      acc_reg       <= ACC_INIT;
      flags_reg     <= '0;
      halt_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      load_ptr_reg  <= load_ptr_next;
      last_reg      <= last_next;
      ir_reg        <= ir_next;
      acc_reg       <= acc_next;
      flags_reg     <= flags_next;
      halt_pend_reg <= halt_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    load_ptr_next  = load_ptr_reg;
    last_next      = last_reg;
    ir_next        = ir_reg;
    acc_next       = acc_reg;
    flags_next     = flags_reg;
    halt_pend_next = halt_pend_reg;
    mem_addr       = pc_reg;
    mem_rw         = 1'b1;
    load_ready     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        halt_pend_next = 1'b0;
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          acc_next   = ACC_INIT;
          flags_next = '0;
          last_next  = prog_last;
        end else if (load_valid) begin
          state_next    = S_LOAD;
          load_ptr_next = '0;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = load_ptr_reg;
        if (load_valid) begin
          mem_rw        = 1'b0;
          load_ptr_next = load_ptr_reg + ADDR_W'(1);
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        // A halt request seen mid-instruction is remembered until EXEC retires it
        halt_pend_next = halt_pend_reg | halt_req;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        halt_pend_next = halt_pend_reg | halt_req;
        ir_next        = mem_rdata;
        state_next     = S_EXEC;
      end
      S_EXEC: begin
        flags_next = {alu_negative, alu_carry, alu_zero};
        if (ir_reg[INSTR_W-1 -: 3] != OP_CMP) begin
          acc_next = alu_result;
        end
        if (halt_req || halt_pend_reg) begin
          state_next     = S_HALTED;
          halt_pend_next = 1'b0;
        end else if (pc_reg == last_reg) begin
          state_next = S_DONE;
        end else begin
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = S_FETCH;
        end
      end
      S_DONE:   state_next = S_IDLE;
      S_HALTED: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign mem_wdata   = load_data;
  assign alu_opcode  = ir_reg[INSTR_W-1 -: 3];
  assign alu_operand = ir_reg[DATA_W-1:0];
  assign alu_in1     = acc_reg;
  assign flags       = flags_reg;
  assign busy        = (state_reg == S_LOAD) || (state_reg == S_FETCH) ||
                       (state_reg == S_DECODE) || (state_reg == S_EXEC);
  assign done        = (state_reg == S_DONE);
  assign halted      = (state_reg == S_HALTED);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: bench-side memory and ALU, program-level execution model,
// randomized loads and runs plus directed scenarios with literal expectations.
module tb_alu_seq_ctrl;

  localparam logic [7:0] ACC_INIT = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  prog_last = '0;
  logic        halt_req = 1'b0;
  logic        load_valid = 1'b0;
  logic [10:0] load_data = '0;
  logic        load_ready;
  logic [5:0]  mem_addr;
  logic        mem_rw;
  logic [10:0] mem_wdata;
  logic [10:0] mem_rdata;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_operand;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_carry, alu_negative;
  logic [2:0]  flags;
  logic        busy, done, halted;

  alu_seq_ctrl #(.ADDR_W(6), .INSTR_W(11), .DATA_W(8), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_last(prog_last), .halt_req(halt_req),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_operand(alu_operand), .alu_in1(alu_in1),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .flags(flags), .busy(busy), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory with registered read
  logic [10:0] mem [64];
  always @(posedge clk) begin
    if (!mem_rw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Test ALU: 0 PASS, 1 AND, 2 ADD, 3 SUB (magnitude, N=a<b), 4 CMP, 5 XOR, 6 OR, 7 NOT
  function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, n;
    c = 1'b0; n = 1'b0; r = '0; s = '0;
    case (op)
      3'd0: r = b;
      3'd1: r = a & b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'd3, 3'd4: begin r = (a >= b) ? a - b : b - a; c = (a >= b); n = (a < b); end
      3'd5: r = a ^ b;
      3'd6: r = a | b;
      default: r = ~a;
    endcase
    if (op != 3'd3 && op != 3'd4) n = r[7];
    return {n, c, (r == 8'h00), r};
  endfunction

  always_comb {alu_negative, alu_carry, alu_zero, alu_result} = alu_f(alu_opcode, alu_in1, alu_operand);

  int total = 0;
  int bad = 0;
  logic [10:0] exp_mem [64];
  logic [10:0] wq [$];
  logic [7:0]  obs_acc [64];
  logic [2:0]  obs_fl [64];
  int  done_cyc;
  logic halted_seen;
  logic prev_v;
  int  lptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_mem_rw"}, mem_rw, 1);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_acc"}, alu_in1, ACC_INIT);
    chk({tag, "_opcode"}, alu_opcode, 0);
    chk({tag, "_operand"}, alu_operand, 0);
  endtask

  // One bus cycle of the load port; a beat is accepted when valid meets ready,
  // and ready follows a valid offered in the previous cycle.
  task automatic load_cycle(input logic v, input logic [10:0] d);
    logic acc_b;
    @(posedge clk); #1;
    load_valid = v;
    load_data  = d;
    @(negedge clk);
    if (!prev_v) lptr = 0;
    acc_b = v && prev_v;
    chk("load_ready", load_ready, prev_v);
    chk("load_busy", busy, prev_v);
    chk("load_mem_rw", mem_rw, !acc_b);
    if (acc_b) begin
      chk("load_addr", mem_addr, lptr);
      chk("load_wdata", mem_wdata, d);
      exp_mem[lptr] = d;
      lptr = (lptr + 1) % 64;
    end
    prev_v = v;
  endtask

  task automatic load_words(input int gap_pct);
    int idx, cyc;
    logic v;
    idx = 0; cyc = 0; prev_v = 1'b0; lptr = 0;
    while (idx < wq.size() && cyc < 4000) begin
      v = (gap_pct > 0 && $urandom_range(99) < gap_pct) ? 1'b0 : 1'b1;
      if (v && prev_v) begin
        load_cycle(v, wq[idx]);
        idx++;
      end else begin
        load_cycle(v, wq[idx]);
      end
      cyc++;
    end
    chk("load_bound", (idx == wq.size()), 1);
    load_cycle(1'b0, '0);
    load_cycle(1'b0, '0);
    $display("load: words=%0d gap_pct=%0d cycles=%0d", wq.size(), gap_pct, cyc);
  endtask

  // Runs program 0..last; halt_k pulses halt_req in that instruction's DECODE,
  // abort_k asserts rst during that instruction's EXEC.
  task automatic run_prog(input int last, input int halt_k, input int abort_k, input bit with_lv);
    logic [7:0]  a;
    logic [2:0]  f;
    logic [10:0] r, w;
    int n_exec, cyc;
    logic exp_halt;
    a = ACC_INIT; f = '0; cyc = 0; done_cyc = -1; halted_seen = 1'b0;
    exp_halt = (halt_k >= 0 && halt_k <= last);
    n_exec = exp_halt ? halt_k + 1 : last + 1;
    @(posedge clk); #1;
    start = 1'b1;
    prog_last = last[5:0];
    if (with_lv) begin load_valid = 1'b1; load_data = 11'h7ff; end
    @(posedge clk); #1;
    start = 1'b0;
    prog_last = 6'($urandom);
    for (int k = 0; k < n_exec; k++) begin
      w = exp_mem[k];
      @(negedge clk); cyc++;
      chk("fetch_busy", busy, 1);
      chk("fetch_addr", mem_addr, k);
      chk("fetch_rw", mem_rw, 1);
      chk("fetch_ready", load_ready, 0);
      chk("fetch_done", done | halted, 0);
      if (k > 0) begin
        obs_acc[k-1] = alu_in1; obs_fl[k-1] = flags;
        chk("acc", alu_in1, a);
        chk("flags", flags, f);
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      if (k == halt_k) halt_req = 1'b1;
      @(negedge clk); cyc++;
      chk("decode_busy", busy, 1);
      chk("decode_rw", mem_rw, 1);
      chk("decode_done", done | halted, 0);
      @(posedge clk); #1;
      halt_req = 1'b0;
      @(negedge clk); cyc++;
      chk("exec_opcode", alu_opcode, w[10:8]);
      chk("exec_operand", alu_operand, w[7:0]);
      chk("exec_in1", alu_in1, a);
      chk("exec_flags", flags, f);
      chk("exec_busy", busy, 1);
      chk("exec_rw", mem_rw, 1);
      if (k == abort_k) begin
        #1 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("run: last=%0d aborted by reset in EXEC of instr %0d", last, k);
        return;
      end
      r = alu_f(w[10:8], a, w[7:0]);
      f = r[10:8];
      if (w[10:8] != 3'b100) a = r[7:0];
      @(posedge clk); #1;
    end
    @(negedge clk); cyc++;
    obs_acc[n_exec-1] = alu_in1; obs_fl[n_exec-1] = flags;
    if (done) done_cyc = cyc;
    halted_seen = halted;
    chk("end_acc", alu_in1, a);
    chk("end_flags", flags, f);
    chk("end_done", done, !exp_halt);
    chk("end_halted", halted, exp_halt);
    chk("end_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_pulse", done | halted, 0);
    chk("idle_busy", busy, 0);
    chk("idle_acc_held", alu_in1, a);
    chk("idle_flags_held", flags, f);
    $display("run: last=%0d exec=%0d acc=%02h flags=%03b halt=%0d", last, n_exec, a, f, exp_halt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, hk;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // 65 beats: the last word wraps onto address 0
    wq.delete();
    for (int i = 0; i < 65; i++) wq.push_back(11'($urandom));
    load_words(0);
    for (int i = 0; i < 64; i++) chk($sformatf("mem_img[%0d]", i), mem[i], exp_mem[i]);
    chk("wrap_word65", mem[0], wq[64]);
    chk("wrap_word2", mem[1], wq[1]);

    // Directed program: ADD 05, ADD FF, CMP 04
    wq = '{11'h205, 11'h2FF, 11'h404};
    load_words(0);
    run_prog(2, -1, -1, 1'b0);
    chk("lit_acc0", obs_acc[0], 8'h05);
    chk("lit_acc1", obs_acc[1], 8'h04);
    chk("lit_fl1", obs_fl[1], 3'b010);
    chk("lit_acc2", obs_acc[2], 8'h04);
    chk("lit_fl2", obs_fl[2], 3'b011);
    chk("lit_done_cyc", done_cyc, 10);

    // SUB magnitude then OR
    wq = '{11'h201, 11'h303, 11'h600};
    load_words(0);
    run_prog(2, -1, -1, 1'b0);
    chk("lit_sub_acc", obs_acc[1], 8'h02);
    chk("lit_sub_fl", obs_fl[1], 3'b100);
    chk("lit_or_acc", obs_acc[2], 8'h02);
    chk("lit_or_fl", obs_fl[2], 3'b000);

    // Halt during DECODE of instruction 2 of 4
    wq = '{11'h201, 11'h202, 11'h204, 11'h208};
    load_words(0);
    run_prog(3, 1, -1, 1'b0);
    chk("lit_halt_acc", obs_acc[1], 8'h03);
    chk("lit_halt_seen", halted_seen, 1);
    chk("lit_halt_nodone", done_cyc, -1);

    // start and load_valid together: run wins, no write
    run_prog(3, -1, -1, 1'b1);
    chk("lit_lv_acc", obs_acc[3], 8'h0F);
    for (int i = 0; i < 4; i++) chk($sformatf("lv_mem[%0d]", i), mem[i], exp_mem[i]);

    // Reset in EXEC, then a clean rerun
    run_prog(3, -1, 1, 1'b0);
    run_prog(3, -1, -1, 1'b0);
    chk("lit_rerun_acc", obs_acc[3], 8'h0F);

    // Gapped load followed by a run over the loaded image
    wq.delete();
    for (int i = 0; i < 24; i++) wq.push_back(11'($urandom));
    load_words(30);
    run_prog(7, -1, -1, 1'b0);

    // Randomized programs with occasional halts
    for (int t = 0; t < 8; t++) begin
      wq.delete();
      last = $urandom_range(0, 11);
      for (int i = 0; i <= last; i++) wq.push_back(11'($urandom));
      load_words(0);
      hk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, last) : -1;
      run_prog(last, hk, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
